// File: rtl/operand_loader_if.sv
// Operand input stream: one DATA_WIDTH word per valid/ready handshake.
// master drives in_data/in_valid, slave (the loader) drives in_ready.
interface operand_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/operand_loader.sv
// operand_loader: captures operand vectors A then B (DEPTH words each)
// from in_if while loaddata is high, then raises inputdata_ready.
// Ports: clk, reset (async, active-high), loaddata, in_if (stream),
// compute_done, rd_addr -> rd_a/rd_b (comb), inputdata_ready, load_count.
module operand_loader #(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 4,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  loaddata,
    operand_loader_if.slave       in_if,
    input  logic                  compute_done,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_a,
    output logic [DATA_WIDTH-1:0] rd_b,
    output logic                  inputdata_ready,
    output logic [ADDR_W:0]       load_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        DONE
    } state_e;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic                  ird_q;
    logic [DATA_WIDTH-1:0] buf_a_q [DEPTH];
    logic [DATA_WIDTH-1:0] buf_b_q [DEPTH];

    logic in_rdy;
    logic acc;
    logic last;
    logic addr_ok;

    assign acc  = in_if.in_valid & in_rdy;
    assign last = (idx_q == LAST_C);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; the index is cleared on every vector boundary
    // so it never addresses past DEPTH-1.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (loaddata) begin
                    state_d = LOAD_A;
                    idx_d   = '0;
                end
            end
            LOAD_A: begin
                if (acc) begin
                    if (last) begin
                        state_d = LOAD_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (acc) begin
                    if (last) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                if (compute_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_rdy     = 1'b0;
        load_count = '0;
        unique case (state_q)
            LOAD_A,
            LOAD_B: begin
                in_rdy     = loaddata;
                load_count = {1'b0, idx_q};
            end
            DONE: begin
                load_count = DEPTH_C;
            end
            default: begin
                in_rdy     = 1'b0;
                load_count = '0;
            end
        endcase
    end

    assign in_if.in_ready = in_rdy;

    // Ready follows DONE by one cycle on both edges of the phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ird_q <= 1'b0;
        end else begin
            ird_q <= (state_q == DONE);
        end
    end

    assign inputdata_ready = ird_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_a_q[i] <= '0;
                buf_b_q[i] <= '0;
            end
        end else if (acc) begin
            if (state_q == LOAD_A) begin
                buf_a_q[idx_q] <= in_if.in_data;
            end
            if (state_q == LOAD_B) begin
                buf_b_q[idx_q] <= in_if.in_data;
            end
        end
    end

    // Guards unused addresses when DEPTH is not a power of two.
    assign addr_ok = ({1'b0, rd_addr} < DEPTH_C);
    assign rd_a    = addr_ok ? buf_a_q[rd_addr] : '0;
    assign rd_b    = addr_ok ? buf_b_q[rd_addr] : '0;

endmodule

// File: doc/operand_loader.md
# operand_loader

Operand-loading stage placed directly upstream of the load/multiply control unit. It captures two operand vectors (A then B, DEPTH words each) from a valid/ready input stream while the control unit holds `loaddata` high. It raises `inputdata_ready` once both vectors are complete, and exposes the stored operands to the multiplier through a combinational read port. It drops `inputdata_ready` when the multiplier signals completion, which returns the control unit to its loading state.

## Interface
- DATA_WIDTH, 8, width of each operand word
- DEPTH, 4, words per operand vector (≥2); ADDR_W = $clog2(DEPTH)

- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- loaddata  in  1  load enable from control unit
- in_data  in  DATA_WIDTH  incoming operand word
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- compute_done  in  1  single-cycle pulse from multiplier: operands consumed
- rd_addr  in  ADDR_W  operand read index
- rd_a  out  DATA_WIDTH  buf_a[rd_addr], combinational
- rd_b  out  DATA_WIDTH  buf_b[rd_addr], combinational
- inputdata_ready  out  1  both vectors loaded; registered
- load_count  out  ADDR_W+1  words accepted into the current vector

## Operation
- States: IDLE, LOAD_A, LOAD_B, DONE.
- Reset values:
  - State = IDLE.
  - buf_a and buf_b entries = 0.
  - Index counter = 0.
  - inputdata_ready = 0, in_ready = 0, load_count = 0.
- Accept condition: a word is accepted when in_valid & in_ready at a clock edge.
- in_ready = loaddata & (state == LOAD_A or LOAD_B). It is combinational and is 0 in IDLE and DONE.
- IDLE:
  - loaddata=1 → LOAD_A with index cleared.
  - Otherwise remain in IDLE.
- LOAD_A:
  - Each accepted word is written to buf_a[index], then index increments.
  - Acceptance of word DEPTH-1 → LOAD_B with index=0.
- LOAD_B: same as LOAD_A into buf_b. Acceptance of word DEPTH-1 → DONE.
- DONE:
  - inputdata_ready=1.
  - Buffers are frozen.
  - compute_done=1 → IDLE with inputdata_ready=0.
- load_count equals the index, reading 0..DEPTH-1 during loading. It shows DEPTH in DONE and 0 in IDLE.
- Boundary rules:
  - loaddata low during LOAD_A/LOAD_B: pause. in_ready=0, index and state hold, and no data is lost. Loading resumes when loaddata returns high.
  - in_valid with in_ready=0: word ignored, no state change.
  - compute_done outside DONE: ignored.
  - loaddata high in DONE: no effect until compute_done.
  - Index wrap: the index never exceeds DEPTH-1 while writing. No wrap-around writes.
  - Reset mid-load: immediate return to reset values. A partial vector is discarded, and the next load starts again at A[0].
  - rd_addr ≥ DEPTH (non-power-of-2 DEPTH): rd_a and rd_b return 0.

## Timing
- One word is accepted per cycle at full throughput. Total load time is 2·DEPTH accepted cycles plus 1 IDLE→LOAD_A cycle.
- inputdata_ready rises on the clock edge after the edge that accepts B[DEPTH-1].
- inputdata_ready falls on the clock edge after the edge that samples compute_done=1.
- The earliest next in_ready is one cycle later: DONE→IDLE→LOAD_A.
- The buffer write is visible on rd_a/rd_b in the cycle after acceptance.
- The reset response is asynchronous. Outputs go to their reset values without waiting for a clock edge.

## Test plan
- Reset mid-LOAD_B: assert reset after 2 B words.
  - Required: outputs and buffers become 0 asynchronously.
  - Reload 1..8 → rd_b[0]=5.
- Full load, DEPTH=4, DATA_WIDTH=8: hold loaddata=1 and stream 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with in_valid=1.
  - Required: inputdata_ready=1 one cycle after 0x88.
  - Required: rd_addr=2 → rd_a=0x33, rd_b=0x77.
  - Required: load_count=4.
- Bubbles: in_valid toggles 1/0 during the same stream.
  - Required: same buffer contents.
  - Required: inputdata_ready asserts one cycle after the 8th accepted word.
- Pause: drop loaddata after 3 A words for 5 cycles while in_valid=1 with 0xEE.
  - Required: in_ready=0 and 0xEE is not stored.
  - Required: after resume, A[3] takes the next valid word.
- Handback: in DONE, pulse compute_done.
  - Required: inputdata_ready=0 next cycle.
  - Required: with loaddata=1, in_ready=1 one cycle later.
  - Required: a new stream 0x01..0x08 fully overwrites the buffers.
- Spurious inputs: pulse compute_done in LOAD_A, and drive in_valid in IDLE with loaddata=0.
  - Required: no state change and no buffer writes.
  - Required: load_count unchanged.
